// File: rtl/voice_envelope.sv
// Per-voice ADSR envelope generator. A single update datapath is time-multiplexed
// across all voices: once per envelope tick, voices 0..NUM_VOICES-1 are serviced on
// consecutive cycles. Levels and states are held per voice; outputs are registered.
module voice_envelope #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned LVL_W      = 16,
  parameter int unsigned TICK_DIV   = 960
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [NUM_VOICES-1:0] gate_i,
  input  logic [LVL_W-1:0]      attack_rate_i,
  input  logic [LVL_W-1:0]      decay_rate_i,
  input  logic [LVL_W-1:0]      sustain_level_i,
  input  logic [LVL_W-1:0]      release_rate_i,
  output logic [31:0]           voice_volumes_o [NUM_VOICES],
  output logic [NUM_VOICES-1:0] active_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [LVL_W-1:0] MaxLvl  = '1;
  localparam logic [CntW-1:0]  CntLast = CntW'(TICK_DIV - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(NUM_VOICES - 1);

  typedef enum logic [2:0] {StIdle, StAttack, StDecay, StSustain, StRelease} state_e;

  // Reset release is taken on the first clock edge so the divider starts cleanly.
  logic            run_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            busy_q, busy_d;
  logic [IdxW-1:0] idx_q, idx_d;

  state_e                  state_q [NUM_VOICES];
  logic [LVL_W-1:0]        lvl_q   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   prev_q;

  // Service datapath signals for the voice currently selected by idx_q.
  logic             g, p;
  state_e           st_cur, st_new, att_st, rel_st, dec_st;
  logic [LVL_W-1:0] lvl_cur, lvl_new, att_lvl, rel_lvl, dec_lvl;
  logic [LVL_W:0]   att_sum, dec_floor;
  logic             att_sat, rel_done, dec_done;

  // Synchronous release of the internal run enable.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) run_q <= 1'b0;
    else           run_q <= 1'b1;
  end

  // Tick divider next state: counts 0..TICK_DIV-1 and wraps.
  always_comb begin
    tick  = run_q && (cnt_q == CntLast);
    cnt_d = cnt_q;
    if (!run_q)    cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + CntW'(1);
  end

  // Sweep sequencer next state: busy for exactly NUM_VOICES cycles after each tick.
  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    if (tick) begin
      busy_d = 1'b1;
      idx_d  = '0;
    end else if (busy_q) begin
      if (idx_q == IdxLast) begin
        busy_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  // Divider and sweep registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      idx_q  <= idx_d;
    end
  end

  // Envelope update for the serviced voice; gate edges take precedence over the state step.
  always_comb begin
    g       = gate_i[idx_q];
    p       = prev_q[idx_q];
    st_cur  = state_q[idx_q];
    lvl_cur = lvl_q[idx_q];

    // Attack: saturating add computed one bit wider.
    att_sum = {1'b0, lvl_cur} + {1'b0, attack_rate_i};
    att_sat = att_sum >= {1'b0, MaxLvl};
    att_lvl = att_sat ? MaxLvl : att_sum[LVL_W-1:0];
    att_st  = att_sat ? StDecay : StAttack;

    // Release: floored at zero without wrapping.
    rel_done = lvl_cur <= release_rate_i;
    rel_lvl  = rel_done ? '0 : lvl_cur - release_rate_i;
    rel_st   = rel_done ? StIdle : StRelease;

    // Decay: lvl <= sustain + rate also covers a sustain already at or above the level.
    dec_floor = {1'b0, sustain_level_i} + {1'b0, decay_rate_i};
    dec_done  = {1'b0, lvl_cur} <= dec_floor;
    dec_lvl   = dec_done ? sustain_level_i : lvl_cur - decay_rate_i;
    dec_st    = dec_done ? StSustain : StDecay;

    st_new  = st_cur;
    lvl_new = lvl_cur;
    if (g && !p) begin
      // Retrigger keeps the current level.
      st_new  = att_st;
      lvl_new = att_lvl;
    end else if (!g && p && (st_cur != StIdle)) begin
      st_new  = rel_st;
      lvl_new = rel_lvl;
    end else begin
      unique case (st_cur)
        StAttack: begin
          st_new  = att_st;
          lvl_new = att_lvl;
        end
        StDecay: begin
          st_new  = dec_st;
          lvl_new = dec_lvl;
        end
        StSustain: begin
          st_new  = StSustain;
          lvl_new = sustain_level_i;
        end
        StRelease: begin
          st_new  = rel_st;
          lvl_new = rel_lvl;
        end
        default: begin
          st_new  = StIdle;
          lvl_new = '0;
        end
      endcase
    end
  end

  // Per-voice state, level and gate history; only the serviced voice changes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        state_q[i] <= StIdle;
        lvl_q[i]   <= '0;
      end
      prev_q <= '0;
    end else if (busy_q) begin
      state_q[idx_q] <= st_new;
      lvl_q[idx_q]   <= lvl_new;
      prev_q[idx_q]  <= g;
    end
  end

  // Outputs decoded straight from the per-voice registers.
  always_comb begin
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      voice_volumes_o[i] = 32'(lvl_q[i]);
      active_o[i]        = (state_q[i] != StIdle);
    end
    busy_o = busy_q;
  end

endmodule
